// File: rtl/riscv_multicycle_if.sv
`default_nettype none
// ==================================================================
// riscv_multicycle_if : data-memory req/ack bus (core is the master)
// Revision 1.0 - initial release
// ==================================================================
interface riscv_multicycle_if #(
  parameter int XLEN = 64
);
  logic            req;
  logic            we;
  logic [XLEN-1:0] addr;
  logic [XLEN-1:0] wdata;
  logic [XLEN-1:0] rdata;
  logic            ack;

  modport master (
    output req,
    output we,
    output addr,
    output wdata,
    input  rdata,
    input  ack
  );

  modport slave (
    input  req,
    input  we,
    input  addr,
    input  wdata,
    output rdata,
    output ack
  );
endinterface
`default_nettype wire

// File: rtl/riscv_multicycle.sv
`default_nettype none
// ==================================================================
// riscv_multicycle : multi-cycle RV64/RV32 subset core, req/ack dmem
// Revision 1.0 - initial release
// ==================================================================
module riscv_multicycle #(
  parameter int              XLEN      = 64,
  parameter int              IMEM_ADDR = 8,
  parameter logic [XLEN-1:0] RESET_PC  = '0
) (
  input  wire                clk,
  input  wire                rst_n,
  riscv_multicycle_if.master dmem,
  output logic [XLEN-1:0]    pc,
  output logic               retire,
  output logic               halted
);

  localparam logic [6:0]      c_op_r    = 7'b0110011;
  localparam logic [6:0]      c_op_imm  = 7'b0010011;
  localparam logic [6:0]      c_op_ld   = 7'b0000011;
  localparam logic [6:0]      c_op_sd   = 7'b0100011;
  localparam logic [6:0]      c_op_beq  = 7'b1100011;
  localparam logic [XLEN-1:0] c_pc_step = XLEN'(4);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [31:0]     ir_q, ir_d;
  logic [XLEN-1:0] a_q, a_d;
  logic [XLEN-1:0] b_q, b_d;
  logic [XLEN-1:0] imm_q, imm_d;
  logic [XLEN-1:0] aluout_q, aluout_d;
  logic [XLEN-1:0] mdr_q, mdr_d;
  logic            req_q, req_d;
  logic            we_q, we_d;
  logic            retire_q, retire_d;
  logic            halted_q, halted_d;

  logic [31:0]     imem [2**IMEM_ADDR];
  logic [XLEN-1:0] rf   [32];

  logic            rf_we;
  logic [XLEN-1:0] rf_wdata;

  // Field decode always works on IR, which stays stable from DECODE to WB
  logic [6:0]      opcode;
  logic [6:0]      funct7;
  logic [2:0]      funct3;
  logic [4:0]      rd;
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic            is_r;
  logic            is_addi;
  logic            is_ld;
  logic            is_sd;
  logic            is_beq;
  logic            is_legal;

  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_s;
  logic [XLEN-1:0] imm_b;
  logic [XLEN-1:0] imm_sel;
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  logic [XLEN-1:0] alu_result;
  logic [XLEN-1:0] pc_seq;
  logic [XLEN-1:0] branch_target;
  logic [IMEM_ADDR-1:0] imem_idx;

  assign opcode = ir_q[6:0];
  assign rd     = ir_q[11:7];
  assign funct3 = ir_q[14:12];
  assign rs1    = ir_q[19:15];
  assign rs2    = ir_q[24:20];
  assign funct7 = ir_q[31:25];

  assign is_r    = (opcode == c_op_r) &&
                   (((funct7 == 7'h00) && ((funct3 == 3'b000) || (funct3 == 3'b111) ||
                                           (funct3 == 3'b110))) ||
                    ((funct7 == 7'h20) && (funct3 == 3'b000)));
  assign is_addi  = (opcode == c_op_imm) && (funct3 == 3'b000);
  assign is_ld    = (opcode == c_op_ld)  && (funct3 == 3'b011);
  assign is_sd    = (opcode == c_op_sd)  && (funct3 == 3'b011);
  assign is_beq   = (opcode == c_op_beq) && (funct3 == 3'b000);
  assign is_legal = is_r || is_addi || is_ld || is_sd || is_beq;

  assign imm_i = {{(XLEN-12){ir_q[31]}}, ir_q[31:20]};
  assign imm_s = {{(XLEN-12){ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
  assign imm_b = {{(XLEN-13){ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};

  always_comb begin
    imm_sel = imm_i;
    if (is_sd) begin
      imm_sel = imm_s;
    end else if (is_beq) begin
      imm_sel = imm_b;
    end
  end

  assign rs1_val  = (rs1 == 5'd0) ? '0 : rf[rs1];
  assign rs2_val  = (rs2 == 5'd0) ? '0 : rf[rs2];
  assign imem_idx = pc_q[IMEM_ADDR+1:2];
  assign pc_seq   = pc_q + c_pc_step;
  assign branch_target = (a_q == b_q) ? (pc_q + imm_q) : pc_seq;
  assign rf_wdata = is_ld ? mdr_q : aluout_q;

  always_comb begin
    alu_result = a_q + imm_q;
    if (is_r) begin
      case (funct3)
        3'b111:  alu_result = a_q & b_q;
        3'b110:  alu_result = a_q | b_q;
        default: alu_result = funct7[5] ? (a_q - b_q) : (a_q + b_q);
      endcase
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    a_d      = a_q;
    b_d      = b_q;
    imm_d    = imm_q;
    aluout_d = aluout_q;
    mdr_d    = mdr_q;
    req_d    = req_q;
    we_d     = we_q;
    retire_d = 1'b0;
    halted_d = halted_q;
    rf_we    = 1'b0;

    case (state_q)
      S_FETCH: begin
        ir_d    = imem[imem_idx];
        state_d = S_DECODE;
      end
      S_DECODE: begin
        a_d   = rs1_val;
        b_d   = rs2_val;
        imm_d = imm_sel;
        if (is_legal) begin
          state_d = S_EXEC;
        end else begin
          state_d  = S_HALT;
          halted_d = 1'b1;
        end
      end
      S_EXEC: begin
        if (is_beq) begin
          if (branch_target[1:0] != 2'b00) begin
            state_d  = S_HALT;
            halted_d = 1'b1;
          end else begin
            pc_d     = branch_target;
            retire_d = 1'b1;
            state_d  = S_FETCH;
          end
        end else if (is_ld || is_sd) begin
          // Request is registered so it is clean from the first MEM cycle
          aluout_d = a_q + imm_q;
          req_d    = 1'b1;
          we_d     = is_sd;
          state_d  = S_MEM;
        end else begin
          aluout_d = alu_result;
          state_d  = S_WB;
        end
      end
      S_MEM: begin
        if (dmem.ack) begin
          req_d = 1'b0;
          if (is_ld) begin
            mdr_d   = dmem.rdata;
            state_d = S_WB;
          end else begin
            pc_d     = pc_seq;
            retire_d = 1'b1;
            state_d  = S_FETCH;
          end
        end
      end
      S_WB: begin
        rf_we    = 1'b1;
        pc_d     = pc_seq;
        retire_d = 1'b1;
        state_d  = S_FETCH;
      end
      S_HALT: begin
        halted_d = 1'b1;
      end
      default: begin
        state_d  = S_HALT;
        halted_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_FETCH;
      pc_q     <= RESET_PC;
      ir_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      imm_q    <= '0;
      aluout_q <= '0;
      mdr_q    <= '0;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      retire_q <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      a_q      <= a_d;
      b_q      <= b_d;
      imm_q    <= imm_d;
      aluout_q <= aluout_d;
      mdr_q    <= mdr_d;
      req_q    <= req_d;
      we_q     <= we_d;
      retire_q <= retire_d;
      halted_q <= halted_d;
    end
  end

  // Register file has no reset; WB is unreachable while rst_n is low
  always_ff @(posedge clk) begin
    if (rf_we && (rd != 5'd0)) begin
      rf[rd] <= rf_wdata;
    end
  end

  assign dmem.req   = req_q;
  assign dmem.we    = we_q;
  assign dmem.addr  = aluout_q;
  assign dmem.wdata = b_q;
  assign pc         = pc_q;
  assign retire     = retire_q;
  assign halted     = halted_q;

endmodule
`default_nettype wire

// File: doc/riscv_multicycle.md
# riscv_multicycle

Multi-cycle RV64 core, the parametrised successor to the single-cycle core. Each instruction runs through a registered FETCH/DECODE/EXEC/MEM/WB state machine, so the datapath carries no combinational loop from instruction memory to data memory. Data memory moves to an external req/ack port with wait-state support. Instruction memory stays internal. XLEN, memory depths and reset vector are parameters.

## Interface
- XLEN, 64, datapath and register width (32 or 64)
- IMEM_ADDR, 8, log2 of instruction memory depth in 32-bit words
- RESET_PC, 0, PC value loaded on reset (word-aligned)
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- dmem_req  out  1  data memory request, held until acknowledged
- dmem_we  out  1  1 = store, 0 = load; valid while dmem_req
- dmem_addr  out  XLEN  byte address (ALU result)
- dmem_wdata  out  XLEN  store data (rs2)
- dmem_rdata  in  XLEN  load data, sampled on the cycle dmem_ack=1
- dmem_ack  in  1  one-cycle completion strobe from memory
- pc  out  XLEN  current PC register
- retire  out  1  one-cycle pulse when an instruction completes
- halted  out  1  sticky, set on illegal opcode or misaligned branch target

## Operation
- Instruction memory: 2**IMEM_ADDR words, indexed by pc[IMEM_ADDR+1:2], read synchronously into IR in FETCH. The bench preloads it hierarchically.
- Register file: 32 x XLEN. x0 reads 0 and writes to it are discarded.
- Supported instructions:
  - R-type 0110011: add, sub, and, or; funct7[5] and funct3 select the operation.
  - addi 0010011 with funct3=000.
  - ld 0000011 with funct3=011.
  - sd 0100011 with funct3=011.
  - beq 1100011 with funct3=000.
  - Any other opcode or funct combination is illegal.
- Immediates are sign-extended to XLEN. Arithmetic wraps modulo 2**XLEN.
- FSM states:
  - FETCH: IR <= imem. Go to DECODE.
  - DECODE: A <= rs1, B <= rs2, IMM <= immediate. An illegal opcode goes to HALT.
  - EXEC:
    - beq: if A==B, target = pc+IMM, else pc+4. A target with [1:0]!=0 goes to HALT. Otherwise pc <= target, retire=1, go to FETCH.
    - ld/sd: ALUOUT <= A+IMM, go to MEM.
    - ALU ops: ALUOUT <= result, go to WB.
  - MEM: dmem_req=1, with dmem_we/addr/wdata driven from registers. Stay in MEM until dmem_ack.
    - ld: latch rdata into MDR, go to WB.
    - sd: pc <= pc+4, retire=1, go to FETCH.
  - WB: rd <= (ld ? MDR : ALUOUT), pc <= pc+4, retire=1. Go to FETCH.
  - HALT: terminal. halted=1, pc holds the offending instruction's address. No requests or writes. Exit only by reset.
- dmem_ack outside MEM is ignored.

## Timing
- Reset (asynchronous, immediate): state=FETCH, pc=RESET_PC, dmem_req=0, dmem_we=0, dmem_addr=0, dmem_wdata=0, retire=0, halted=0. Register file contents are not reset.
- Cycles per instruction, with W = wait cycles before ack (W=0 means ack in the first MEM cycle):
  - beq: 3
  - ALU ops: 4
  - sd: 4+W
  - ld: 5+W
- Handshake: dmem_req rises on the first MEM cycle. dmem_req, dmem_we, dmem_addr and dmem_wdata stay stable until the cycle ack is sampled. dmem_req is 0 on the following cycle; there are no back-to-back requests from one instruction.
- retire pulses on the same edge that updates pc.
- Reset asserted during MEM drops dmem_req asynchronously. The outstanding ack is discarded.

## Test plan
- Reset with RESET_PC=0x40:
  - During reset: pc=0x40, dmem_req=0, halted=0, retire=0.
  - After release: first fetch reads word 0x10; pc reaches 0x44 after 4 cycles for an addi.
- Load/add/store program: ld x1,0(x0); ld x2,8(x0) with memory returning 5 and 7; add x3,x1,x2; sd x3,16(x0). Required: store request with dmem_we=1, dmem_addr=16, dmem_wdata=12; four retire pulses.
- beq x1,x1,+8 at pc=0x10 -> pc=0x18 after 3 cycles. beq x1,x2,+8 with x1!=x2 -> pc=0x14.
- Load with ack delayed 3 cycles: dmem_req high for 4 consecutive cycles with addr constant; rd written 1 cycle after ack; total 8 cycles.
- addi x0,x0,5 then add x1,x0,x0 -> x1=0. Opcode 0x00000000 at pc=0x20 -> halted=1, pc stays 0x20, no further retire or dmem_req.
- Reset asserted mid-MEM wait:
  - dmem_req=0 in the same cycle; a late ack causes no register write.
  - After release, execution restarts at RESET_PC.
